regfile_p: RTL
==============

# regfile_p

Parametrised general-purpose register file for the 16-bit CPU datapath, the successor to the fixed 16×16 block. It provides clocked writes, two combinational read ports with optional same-cycle write bypass, a dedicated R0 write port for multiply/divide side results, and a per-register busy scoreboard for multi-cycle operations. It sits between decode (read addresses, reserve requests) and writeback (write port, R0 port).

## Interface
- DATA_W, 16: register width in bits.
- ADDR_W, 4: address width; depth is 2**ADDR_W.
- BYPASS, 1: 1 means a read of a register written this cycle returns the new data; 0 means it returns the stored value.
- INIT_EN, 1: 1 loads the reset table; 0 clears every register to zero.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- read_reg1  input  ADDR_W  read port 1 address.
- read_reg2  input  ADDR_W  read port 2 address.
- read_data1  output  DATA_W  port 1 data (combinational).
- read_data2  output  DATA_W  port 2 data (combinational).
- read_busy1  output  1  busy bit of read_reg1, after bypass.
- read_busy2  output  1  busy bit of read_reg2, after bypass.
- reg_write  input  2  bit1 enables the general write; bit0 enables the R0 write.
- write_reg  input  ADDR_W  general write address.
- write_data  input  DATA_W  general write data.
- r0  input  DATA_W  R0 write data.
- rsv_en  input  1  marks rsv_reg busy.
- rsv_reg  input  ADDR_W  register to reserve.
- busy_vec  output  2**ADDR_W  all busy bits, registered.

## Operation
- **Reset (reset=0, asynchronous):**
  - With INIT_EN=1, R0..R15 load 0000, 7B18, 245B, FF0F, F0FF, 0051, 6666, 00FF, FF88, 0000, 0000, 3099, CCCC, 0002, 0011, 0000 (hex). Each value is zero-extended or truncated to DATA_W. Registers at addresses ≥16 load 0.
  - With INIT_EN=0, every register loads 0.
  - busy_vec resets to 0.
  - Writes and reserves are ignored while reset=0.
- **General write:** when reg_write[1]=1, R[write_reg] takes write_data on the rising edge.
- **R0 write:** when reg_write[0]=1, R[0] takes r0 on the rising edge.
- **Write conflict:** if both writes target R0 in the same cycle, the R0 port wins.
- **Reads:**
  - read_dataN = R[read_regN], combinational.
  - With BYPASS=1, if a write to read_regN is enabled this cycle, read_dataN returns that write's data. The same priority applies: R0 port first, then the general write.
  - With BYPASS=0, reads always return the stored value.
- **Scoreboard:**
  - rsv_en=1 sets busy[rsv_reg] at the clock edge.
  - An enabled write to a register clears its busy bit. The general write clears busy[write_reg]; the R0 write clears busy[0].
  - If a reserve and a write hit the same register in one cycle, the reserve wins and the bit ends at 1, because the write completes an older operation.
  - read_busyN = busy[read_regN]. With BYPASS=1, it reads 0 when a clearing write to that register occurs in the same cycle, unless a reserve of the same register occurs in that cycle.
- R0 is an ordinary register, not hardwired to zero.
- Out-of-range addresses do not exist: the depth is exactly 2**ADDR_W.

## Timing
- Write latency: 1 clock. Data is visible in stored reads the cycle after the edge, or in the same cycle via bypass.
- Read latency: 0 (combinational from the address, the storage and the write inputs).
- Busy latency:
  - A bit set by rsv_en at edge N reads 1 from cycle N+1.
  - A bit cleared by a write at edge N reads 0 from cycle N+1, or in the same cycle with BYPASS=1.
- Reset assertion takes effect immediately, with no clock required. Deassertion is synchronised by the system. The first write is accepted on the first rising edge with reset=1.
- If reset asserts mid-operation, outstanding busy bits are lost and the table values are restored.
- busy_vec is a direct register output with no combinational path from the inputs.

## Test plan
- **Reset table:** pulse reset low with no clock. Then: read_reg1=1 gives read_data1=7B18; read_reg2=C gives CCCC; busy_vec=0.
- **Write and bypass (BYPASS=1):** set write_reg=5, write_data=ABCD, reg_write=10, read_reg1=5. Then: read_data1=ABCD before the edge and stays ABCD after it. With BYPASS=0, it reads 0051 before the edge and ABCD after.
- **Dual write conflict:** set reg_write=11, write_reg=0, write_data=1111, r0=2222. Then: R0 reads 2222 after the edge. Repeat with write_reg=3; then R3=1111 and R0=2222.
- **Scoreboard:**
  - Set rsv_en=1 with rsv_reg=7. Then: busy_vec[7]=1 and read_busy1=1 for read_reg1=7.
  - Write R7=0042. Then: busy clears and read_data1=0042.
  - Reserve and write R7 in the same cycle. Then: busy_vec[7] stays 1.
- **Async reset mid-operation:** reserve R3 and write R3=BEEF, then assert reset between clock edges. Then: busy_vec=0 and R3=FF0F immediately.
- **Parameter sweep:** DATA_W=32, ADDR_W=5, INIT_EN=1. Then: R2=0000245B, R20=0, and writes and reads work at address 1F.

Source files
------------

// File: rtl/regfile_p.sv
// regfile_p: parametrised register file with two combinational read ports (optional write bypass),
// a dedicated R0 write port and a per-register busy scoreboard.
// Latency: writes and busy updates take effect at the next rising edge; reads are combinational.
// No backpressure: every enabled write and reserve is accepted on the edge it is presented.
// Ports: clk, reset (async, active-low)
//        read_reg1/read_reg2 -> read_data1/read_data2, read_busy1/read_busy2
//        reg_write[1]: general write (write_reg, write_data); reg_write[0]: R0 write (r0)
//        rsv_en/rsv_reg: mark a register busy; busy_vec: registered busy bits
module regfile_p #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter bit BYPASS  = 1'b1,
  parameter bit INIT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      read_reg1,
  input  logic [ADDR_W-1:0]      read_reg2,
  output logic [DATA_W-1:0]      read_data1,
  output logic [DATA_W-1:0]      read_data2,
  output logic                   read_busy1,
  output logic                   read_busy2,
  input  logic [1:0]             reg_write,
  input  logic [ADDR_W-1:0]      write_reg,
  input  logic [DATA_W-1:0]      write_data,
  input  logic [DATA_W-1:0]      r0,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_reg,
  output logic [(1<<ADDR_W)-1:0] busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Reset table of the legacy 16x16 block, zero-extended or truncated to DATA_W.
  function automatic logic [DATA_W-1:0] init_val(input int idx);
    logic [15:0]       v;
    logic [DATA_W-1:0] r;
    case (idx)
      1:       v = 16'h7B18;
      2:       v = 16'h245B;
      3:       v = 16'hFF0F;
      4:       v = 16'hF0FF;
      5:       v = 16'h0051;
      6:       v = 16'h6666;
      7:       v = 16'h00FF;
      8:       v = 16'hFF88;
      11:      v = 16'h3099;
      12:      v = 16'hCCCC;
      13:      v = 16'h0002;
      14:      v = 16'h0011;
      default: v = 16'h0000;
    endcase
    r = '0;
    for (int b = 0; b < DATA_W; b++) begin
      if (b < 16) r[b] = v[b[3:0]];
    end
    return r;
  endfunction

  // R0 port assignment comes last so it wins a same-cycle conflict on R0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= INIT_EN ? init_val(i) : '0;
      end
    end else begin
      if (reg_write[1]) regs[write_reg] <= write_data;
      if (reg_write[0]) regs[0]         <= r0;
    end
  end

  // Writes retire older operations; a reserve in the same cycle belongs to a newer
  // operation, so it is applied last and wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write[1]) busy_d[write_reg] = 1'b0;
    if (reg_write[0]) busy_d[0]         = 1'b0;
    if (rsv_en)       busy_d[rsv_reg]   = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic [1:0]        rbusy;

  assign raddr[0] = read_reg1;
  assign raddr[1] = read_reg2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit_r0;
    logic hit_gw;
    logic hit_rsv;
    assign hit_r0  = BYPASS && reg_write[0] && (raddr[p] == '0);
    assign hit_gw  = BYPASS && reg_write[1] && (raddr[p] == write_reg);
    assign hit_rsv = rsv_en && (rsv_reg == raddr[p]);
    assign rdata[p] = hit_r0 ? r0 : (hit_gw ? write_data : regs[raddr[p]]);
    // A same-cycle clearing write shows as not-busy early, unless a new reserve
    // lands on the same register, in which case the stored bit is reported.
    assign rbusy[p] = ((hit_r0 || hit_gw) && !hit_rsv) ? 1'b0 : busy_q[raddr[p]];
  end

  assign read_data1 = rdata[0];
  assign read_data2 = rdata[1];
  assign read_busy1 = rbusy[0];
  assign read_busy2 = rbusy[1];

endmodule
